// File: rtl/clock_enable_divider_pkg.sv
// Shared constants for the single-clock enable divider: default widths, stop code, standard divisors.
// Pure definitions, no logic.
package clk_div_pkg;

  localparam int CNT_W_DEF = 16;
  localparam logic [CNT_W_DEF-1:0] DIV_STOP = '0;

  // Standard cascade ratios for the 1 MHz base tick down to 1 Hz
  localparam int DIV_1M_10K = 100;
  localparam int DIV_10K_1K = 10;
  localparam int DIV_1K_10  = 100;
  localparam int DIV_10_1   = 10;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clock_enable_divider_channel.sv
// One divider channel: counter, active/shadow divisor, registered TC pulse and SQW toggle.
// TC one cycle after the wrapping input tick; all state holds while CE is low.
module div_channel
  import clk_div_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DEF_DIV = 10
) (
  input  logic             CP,
  input  logic             CR,
  input  logic             CE,
  input  logic             IN_TICK,
  input  logic             WE,
  input  logic [CNT_W-1:0] WDIV,
  output logic             TC,
  output logic             SQW
);

  localparam logic [CNT_W-1:0] DEF_D = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] STOP  = CNT_W'(DIV_STOP);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div;
  logic [CNT_W-1:0] shd;
  logic             tc_q;
  logic             sqw_q;

  always_ff @(posedge CP) begin
    if (CR) begin
      cnt   <= '0;
      div   <= DEF_D;
      shd   <= DEF_D;
      tc_q  <= 1'b0;
      sqw_q <= 1'b0;
    end else begin
      if (WE)
        shd <= WDIV;
      if (div == STOP) begin
        // Stopped channel accepts a new divisor at once and restarts from zero
        if (CE)
          tc_q <= 1'b0;
        if (WE) begin
          div <= WDIV;
          cnt <= '0;
        end
      end else if (CE) begin
        tc_q <= 1'b0;
        if (IN_TICK) begin
          if (cnt == div - ONE) begin
            cnt   <= '0;
            tc_q  <= 1'b1;
            sqw_q <= ~sqw_q;
            div   <= WE ? WDIV : shd;
          end else begin
            cnt <= cnt + ONE;
          end
        end
      end
    end
  end

  // A pulse pending when CE drops is held and delivered once counting resumes
  assign TC  = tc_q & CE;
  assign SQW = sqw_q;

endmodule

// File: rtl/clock_enable_divider.sv
// Prescaler plus N_CH divider channels, all on CP; TICK and TC are registered one-cycle pulses.
// CE low freezes every counter and masks the pulse outputs without losing a pending pulse.
module clock_enable_divider
  import clk_div_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int PRE_DIV = 50,
  parameter int DEF_DIV = 10,
  parameter int CASCADE = 1,
  localparam int SEL_W  = sel_width(N_CH)
) (
  input  logic             CP,
  input  logic             CR,
  input  logic             CE,
  input  logic             WE,
  input  logic [SEL_W-1:0] WSEL,
  input  logic [CNT_W-1:0] WDIV,
  output logic             TICK,
  output logic [N_CH-1:0]  TC,
  output logic [N_CH-1:0]  SQW
);

  localparam int PRE_W = sel_width(PRE_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRE_DIV - 1);

  logic [PRE_W-1:0] pre_cnt;
  logic             tick_q;
  logic [N_CH-1:0]  in_tick;
  logic [N_CH-1:0]  ch_we;

  always_ff @(posedge CP) begin
    if (CR) begin
      pre_cnt <= '0;
      tick_q  <= 1'b0;
    end else if (CE) begin
      tick_q  <= (pre_cnt == PRE_LAST);
      pre_cnt <= (pre_cnt == PRE_LAST) ? '0 : pre_cnt + PRE_W'(1);
    end
  end

  assign TICK = tick_q & CE;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    if (k == 0 || CASCADE == 0) begin : g_base
      assign in_tick[k] = TICK;
    end else begin : g_casc
      assign in_tick[k] = TC[k-1];
    end

    // Out-of-range selects never match any channel index
    assign ch_we[k] = WE && (int'(WSEL) == k);

    div_channel #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
    ) u_ch (
      .CP      (CP),
      .CR      (CR),
      .CE      (CE),
      .IN_TICK (in_tick[k]),
      .WE      (ch_we[k]),
      .WDIV    (WDIV),
      .TC      (TC[k]),
      .SQW     (SQW[k])
    );
  end

endmodule
